pe_noc_adapter: RTL and testbench
=================================

// Module: pe_noc_adapter
// PURPOSE
//  PE-side network interface between a neuron and its bufferless XY switch port (i_*_pe/o_*_pe).
//  Ingress: buffers flits delivered by the switch and strips the header for the neuron.
//  Egress: turns each neuron result into NUM_DEST unicast flits, one per next-layer neuron,
//  and holds each flit under switch back-pressure.
// PARAMETERS
//  x_coord     1   X coordinate of this node; goes in the src_x header field
//  y_coord     2   Y coordinate of this node; goes in the src_y header field
//  x_size      2   bits per X coordinate field
//  y_size      2   bits per Y coordinate field
//  data_width  8   payload width
//  total_width 2*x_size+2*y_size+data_width  flit width
//  DEST_X      2   X column of the next-layer neurons
//  DEST_Y0     0   Y of the first destination; destination k is at Y = DEST_Y0+k
//  NUM_DEST    4   destinations per result, 1..2**y_size
//  FIFO_DEPTH  4   ingress FIFO depth, power of 2, >=2
// PORTS
//  clk         in   1            clock; all state changes on the rising edge
//  rstn        in   1            asynchronous active-low reset
//  sw_valid    in   1            switch -> PE flit valid (switch o_valid_pe)
//  sw_data     in   total_width  switch -> PE flit (switch o_data_pe)
//  sw_ready    out  1            adapter can take a flit (drives switch i_ready_pe)
//  sw_o_ready  in   1            switch accepts a PE flit this cycle (switch o_ready_pe)
//  pe_flit_v   out  1            flit to switch valid (drives switch i_valid_pe)
//  pe_flit     out  total_width  flit to switch (drives switch i_data_pe)
//  nrn_in_v    out  1            payload to neuron valid
//  nrn_in_d    out  data_width   payload to neuron
//  nrn_in_src  out  x_size+y_size  {src_x,src_y} of the delivered payload
//  nrn_in_rdy  in   1            neuron consumes the payload
//  nrn_res_v   in   1            neuron result valid (single-cycle pulse)
//  nrn_res_d   in   data_width   neuron result value
//  nrn_res_rdy out  1            adapter can accept a result
// BEHAVIOUR
//  Flit layout, LSB first:
//   [y_size-1:0] dst_y; [x_size+y_size-1:y_size] dst_x; then src_y; then src_x; data at the MSBs.
//  Reset: all outputs 0 except sw_ready=1 and nrn_res_rdy=1; FIFO empty; FSM in IDLE;
//   pending register empty. Reset may assert at any cycle; any transfer in flight is dropped.
//  Ingress FIFO:
//   - sw_ready = ~full. Push when sw_valid & sw_ready; the switch holds its flit while sw_ready=0.
//   - nrn_in_v = ~empty; nrn_in_d and nrn_in_src come from the head entry, no extra latency.
//   - Pop when nrn_in_v & nrn_in_rdy.
//   - Push to an empty FIFO makes nrn_in_v high the next cycle.
//   - Simultaneous push and pop when full: push is refused (sw_ready=0); the pop still happens.
//   - Simultaneous push and pop at any other fill level: occupancy is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
//  Egress FSM, states IDLE and SEND; counter k, $clog2(NUM_DEST)+1 bits:
//   - IDLE: a result (nrn_res_v & nrn_res_rdy) is latched into res_q; go to SEND with k=0.
//     pe_flit_v rises in the following cycle.
//   - SEND: pe_flit_v=1, pe_flit={res_q, x_coord, y_coord, DEST_X, DEST_Y0+k}.
//     The dst_y add is truncated to y_size bits.
//   - Transfer occurs on a cycle with pe_flit_v & sw_o_ready; then k++.
//   - Without a transfer, pe_flit stays stable.
//   - After the transfer with k==NUM_DEST-1: if a result is pending, move it to res_q,
//     clear pending and restart at k=0 with no idle cycle; otherwise return to IDLE.
//  Result intake while in SEND: one pending register.
//   - nrn_res_rdy = ~pending_full, as a registered flag.
//   - A result arriving while pending is full is not allowed: nrn_res_rdy is 0 then.
//   - If the pending register is freed in the same cycle a new result arrives, the new result is stored.
//  The FSM never issues a flit to this node's own coordinates; self-loop goes through the ingress FIFO only when sent by the switch.
// TESTING
//  T1 reset: rstn=0 mid-SEND with k=2 -> the same cycle pe_flit_v=0, sw_ready=1, nrn_in_v=0;
//     after release the FSM is in IDLE.
//  T2 egress, sw_o_ready=1: nrn_res_d=8'hA5 -> 4 consecutive flits.
//     For defaults, pe_flit = {8'hA5,2'd1,2'd2,2'd2,2'dk}, k=0..3; then pe_flit_v=0.
//  T3 backpressure: as T2, with sw_o_ready=0 for 3 cycles at k=1
//     -> flit k=1 is held stable 3 cycles, and all 4 flits are delivered exactly once.
//  T4 pending: second result 8'h3C while sending 8'hA5 -> 8 flits with no gap.
//     A third pulse is impossible: nrn_res_rdy=0 until 8'hA5 finishes.
//  T5 ingress full: nrn_in_rdy=0, push 5 flits -> sw_ready=0 after the 4th, and the 5th is held.
//     Raise nrn_in_rdy -> 5 payloads in order with correct nrn_in_src.
//  T6 simultaneous: FIFO at 2 entries, push and pop in the same cycle
//     -> occupancy stays 2 and order is preserved.

Source files
------------

// File: rtl/pe_noc_adapter.sv
// rtl/pe_noc_adapter.sv - PE-side network interface: ingress flit FIFO and egress unicast fan-out FSM
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   sw_valid/sw_data        flit from the switch into the ingress FIFO
//   sw_ready                ingress FIFO not full
//   sw_o_ready              switch accepts the egress flit this cycle
//   pe_flit_v/pe_flit       egress flit to the switch
//   nrn_in_v/_d/_src        head-of-FIFO payload and its {src_x,src_y}
//   nrn_in_rdy              neuron consumes the head payload
//   nrn_res_v/_d            neuron result pulse and value
//   nrn_res_rdy             adapter can accept a result (registered)
module pe_noc_adapter #(
    parameter int x_coord     = 1,
    parameter int y_coord     = 2,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int data_width  = 8,
    parameter int total_width = 2*x_size + 2*y_size + data_width,
    parameter int DEST_X      = 2,
    parameter int DEST_Y0     = 0,
    parameter int NUM_DEST    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sw_valid,
    input  logic [total_width-1:0]    sw_data,
    output logic                      sw_ready,
    input  logic                      sw_o_ready,
    output logic                      pe_flit_v,
    output logic [total_width-1:0]    pe_flit,
    output logic                      nrn_in_v,
    output logic [data_width-1:0]     nrn_in_d,
    output logic [x_size+y_size-1:0]  nrn_in_src,
    input  logic                      nrn_in_rdy,
    input  logic                      nrn_res_v,
    input  logic [data_width-1:0]     nrn_res_d,
    output logic                      nrn_res_rdy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int KW   = $clog2(NUM_DEST) + 1;
    localparam int SW   = x_size + y_size;
    localparam int SUMW = KW + y_size;

    localparam logic [x_size-1:0] SRC_X    = x_size'(x_coord);
    localparam logic [y_size-1:0] SRC_Y    = y_size'(y_coord);
    localparam logic [x_size-1:0] DST_X    = x_size'(DEST_X);
    localparam bit                SELF_COL = (DEST_X == x_coord);
    localparam logic [KW-1:0]     K_LAST   = KW'(NUM_DEST - 1);

    // ---------------- Ingress FIFO ----------------
    logic [total_width-1:0] mem_q [FIFO_DEPTH];
    logic [total_width-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   empty, full, push, pop;
    logic [total_width-1:0] head;
    logic                   dst_unused;

    assign empty = (wptr_q == rptr_q);
    // Same index, opposite wrap bit: writer is one full lap ahead.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = sw_valid && !full;
    assign pop   = !empty && nrn_in_rdy;
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = sw_data;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

    // The destination field of a delivered flit is this node by construction.
    assign dst_unused = ^head[SW-1:0];

    assign sw_ready   = !full;
    assign nrn_in_v   = !empty;
    assign nrn_in_d   = empty ? '0 : head[total_width-1 -: data_width];
    assign nrn_in_src = empty ? '0 : head[2*SW-1:SW];

    // ---------------- Egress FSM ----------------
    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [data_width-1:0] res_q, res_d;
    logic [data_width-1:0] pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  res_rdy_q, res_rdy_d;
    logic [y_size-1:0]     dst_y;
    logic                  self_hit, flit_v, adv, last, res_acc;

    assign dst_y    = y_size'(SUMW'(DEST_Y0) + SUMW'(k_q));
    // A destination equal to this node is skipped without occupying the switch.
    assign self_hit = SELF_COL && (dst_y == SRC_Y);
    assign flit_v   = (state_q == SEND) && !self_hit;
    assign adv      = (state_q == SEND) && (self_hit || sw_o_ready);
    assign last     = (k_q == K_LAST);
    assign res_acc  = nrn_res_v && res_rdy_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        res_d       = res_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        case (state_q)
            IDLE: begin
                if (res_acc) begin
                    res_d   = nrn_res_d;
                    k_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (adv && last) begin
                    k_d = '0;
                    if (pend_full_q) begin
                        res_d       = pend_q;
                        pend_full_d = 1'b0;
                    end else if (res_acc) begin
                        // Result arriving on the final transfer starts the next burst directly.
                        res_d = nrn_res_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (adv) begin
                        k_d = k_q + KW'(1);
                    end
                    if (res_acc) begin
                        pend_d      = nrn_res_d;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        res_rdy_d = !pend_full_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            res_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            res_rdy_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            res_q       <= res_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            res_rdy_q   <= res_rdy_d;
        end
    end

    assign pe_flit_v   = flit_v;
    assign pe_flit     = flit_v ? {res_q, SRC_X, SRC_Y, DST_X, dst_y} : '0;
    assign nrn_res_rdy = res_rdy_q;

endmodule

// File: tb/tb_pe_noc_adapter.sv
// tb/tb_pe_noc_adapter.sv - directed self-checking bench for pe_noc_adapter
module tb_pe_noc_adapter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sw_valid;
    logic [15:0] sw_data;
    logic        sw_ready;
    logic        sw_o_ready;
    logic        pe_flit_v;
    logic [15:0] pe_flit;
    logic        nrn_in_v;
    logic [7:0]  nrn_in_d;
    logic [3:0]  nrn_in_src;
    logic        nrn_in_rdy;
    logic        nrn_res_v;
    logic [7:0]  nrn_res_d;
    logic        nrn_res_rdy;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int x0;

    always #5 clk = ~clk;

    pe_noc_adapter dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_valid   (sw_valid),
        .sw_data    (sw_data),
        .sw_ready   (sw_ready),
        .sw_o_ready (sw_o_ready),
        .pe_flit_v  (pe_flit_v),
        .pe_flit    (pe_flit),
        .nrn_in_v   (nrn_in_v),
        .nrn_in_d   (nrn_in_d),
        .nrn_in_src (nrn_in_src),
        .nrn_in_rdy (nrn_in_rdy),
        .nrn_res_v  (nrn_res_v),
        .nrn_res_d  (nrn_res_d),
        .nrn_res_rdy(nrn_res_rdy)
    );

    always @(posedge clk) begin
        if (rstn && pe_flit_v && sw_o_ready) xfers <= xfers + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Egress flit: {data, src_x=1, src_y=2, dst_x=2, dst_y=k}
    function automatic logic [15:0] ef(input logic [7:0] d, input int k);
        return {d, 2'd1, 2'd2, 2'd2, 2'(k)};
    endfunction

    // Ingress flit addressed to this node (1,2)
    function automatic logic [15:0] inf(input logic [7:0] d, input logic [1:0] sx, input logic [1:0] sy);
        return {d, sx, sy, 2'd1, 2'd2};
    endfunction

    initial begin
        rstn = 1'b0; sw_valid = 1'b0; sw_data = '0; sw_o_ready = 1'b0;
        nrn_in_rdy = 1'b0; nrn_res_v = 1'b0; nrn_res_d = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sw_ready", 32'(sw_ready), 32'd1);
        chk("rst_res_rdy", 32'(nrn_res_rdy), 32'd1);
        chk("rst_flit_v", 32'(pe_flit_v), 32'd0);
        chk("rst_flit", 32'(pe_flit), 32'd0);
        chk("rst_in_v", 32'(nrn_in_v), 32'd0);
        chk("rst_in_d", 32'(nrn_in_d), 32'd0);
        chk("rst_in_src", 32'(nrn_in_src), 32'd0);
        rstn = 1'b1;
        step();

        // T2: plain fan-out
        sw_o_ready = 1'b1; nrn_res_v = 1'b1; nrn_res_d = 8'hA5;
        step();
        nrn_res_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_v", 32'(pe_flit_v), 32'd1);
            chk("t2_flit", 32'(pe_flit), 32'(ef(8'hA5, i)));
            step();
        end
        chk("t2_done", 32'(pe_flit_v), 32'd0);

        // T3: back-pressure at k=1
        x0 = xfers;
        nrn_res_v = 1'b1; nrn_res_d = 8'hA5;
        step();
        nrn_res_v = 1'b0;
        chk("t3_k0", 32'(pe_flit), 32'(ef(8'hA5, 0)));
        step();
        sw_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_v", 32'(pe_flit_v), 32'd1);
            chk("t3_hold", 32'(pe_flit), 32'(ef(8'hA5, 1)));
            step();
        end
        sw_o_ready = 1'b1;
        chk("t3_k1", 32'(pe_flit), 32'(ef(8'hA5, 1)));
        step();
        chk("t3_k2", 32'(pe_flit), 32'(ef(8'hA5, 2)));
        step();
        chk("t3_k3", 32'(pe_flit), 32'(ef(8'hA5, 3)));
        step();
        chk("t3_done", 32'(pe_flit_v), 32'd0);
        chk("t3_xfers", 32'(xfers - x0), 32'd4);

        // T4: pending result, 8 flits with no gap
        nrn_res_v = 1'b1; nrn_res_d = 8'hA5;
        step();
        chk("t4_rdy0", 32'(nrn_res_rdy), 32'd1);
        chk("t4_f0", 32'(pe_flit), 32'(ef(8'hA5, 0)));
        nrn_res_d = 8'h3C;
        step();
        nrn_res_v = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("t4_rdy_low", 32'(nrn_res_rdy), 32'd0);
            chk("t4_fa", 32'(pe_flit), 32'(ef(8'hA5, i)));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t4_rdy_high", 32'(nrn_res_rdy), 32'd1);
            chk("t4_v", 32'(pe_flit_v), 32'd1);
            chk("t4_fb", 32'(pe_flit), 32'(ef(8'h3C, i)));
            step();
        end
        chk("t4_done", 32'(pe_flit_v), 32'd0);

        // T5: ingress full and drain
        nrn_in_rdy = 1'b0;
        sw_valid = 1'b1; sw_data = inf(8'h11, 2'd0, 2'd0);
        chk("t5_empty", 32'(nrn_in_v), 32'd0);
        step();
        chk("t5_v_next", 32'(nrn_in_v), 32'd1);
        sw_data = inf(8'h22, 2'd3, 2'd1);
        step();
        sw_data = inf(8'h33, 2'd2, 2'd3);
        step();
        chk("t5_ready3", 32'(sw_ready), 32'd1);
        sw_data = inf(8'h44, 2'd1, 2'd0);
        step();
        chk("t5_full", 32'(sw_ready), 32'd0);
        sw_data = inf(8'h55, 2'd0, 2'd3);
        step();
        step();
        chk("t5_still_full", 32'(sw_ready), 32'd0);
        chk("t5_head_held", 32'(nrn_in_d), 32'h11);
        nrn_in_rdy = 1'b1;
        chk("t5_d0", 32'(nrn_in_d), 32'h11);
        chk("t5_s0", 32'(nrn_in_src), 32'h0);
        step();
        chk("t5_reopen", 32'(sw_ready), 32'd1);
        chk("t5_d1", 32'(nrn_in_d), 32'h22);
        chk("t5_s1", 32'(nrn_in_src), 32'hD);
        step();
        sw_valid = 1'b0;
        chk("t5_d2", 32'(nrn_in_d), 32'h33);
        chk("t5_s2", 32'(nrn_in_src), 32'hB);
        step();
        chk("t5_d3", 32'(nrn_in_d), 32'h44);
        chk("t5_s3", 32'(nrn_in_src), 32'h4);
        step();
        chk("t5_d4", 32'(nrn_in_d), 32'h55);
        chk("t5_s4", 32'(nrn_in_src), 32'h3);
        step();
        chk("t5_drained", 32'(nrn_in_v), 32'd0);

        // T6: simultaneous push/pop at 2 entries
        nrn_in_rdy = 1'b0;
        sw_valid = 1'b1; sw_data = inf(8'h66, 2'd2, 2'd2);
        step();
        sw_data = inf(8'h77, 2'd3, 2'd3);
        step();
        sw_data = inf(8'h88, 2'd0, 2'd1);
        nrn_in_rdy = 1'b1;
        chk("t6_h0", 32'(nrn_in_d), 32'h66);
        step();
        sw_valid = 1'b0;
        chk("t6_h1", 32'(nrn_in_d), 32'h77);
        chk("t6_s1", 32'(nrn_in_src), 32'hF);
        step();
        chk("t6_h2", 32'(nrn_in_d), 32'h88);
        chk("t6_s2", 32'(nrn_in_src), 32'h1);
        step();
        chk("t6_empty", 32'(nrn_in_v), 32'd0);
        nrn_in_rdy = 1'b0;

        // T1: reset mid-SEND at k=2 with a full FIFO
        sw_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sw_data = inf(8'(8'hE0 + i), 2'd1, 2'd1);
            step();
        end
        sw_valid = 1'b0;
        chk("t1_full", 32'(sw_ready), 32'd0);
        nrn_res_v = 1'b1; nrn_res_d = 8'h5A;
        step();
        nrn_res_v = 1'b0;
        step();
        step();
        chk("t1_k2", 32'(pe_flit), 32'(ef(8'h5A, 2)));
        rstn = 1'b0;
        #1;
        chk("t1_flit_v", 32'(pe_flit_v), 32'd0);
        chk("t1_sw_ready", 32'(sw_ready), 32'd1);
        chk("t1_in_v", 32'(nrn_in_v), 32'd0);
        chk("t1_res_rdy", 32'(nrn_res_rdy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("t1_idle", 32'(pe_flit_v), 32'd0);
        nrn_res_v = 1'b1; nrn_res_d = 8'hC3;
        step();
        nrn_res_v = 1'b0;
        chk("t1_restart_k0", 32'(pe_flit), 32'(ef(8'hC3, 0)));
        repeat (4) step();
        chk("t1_restart_done", 32'(pe_flit_v), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
